// File: rtl/pipeline_hazard_sequencer_pkg.sv
// Shared definitions for the hazard sequencer: FSM encoding and default widths.
package hazard_defs;
    localparam int REG_AW_DEF = 5;
    localparam int TIMER_W    = 8;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        ERR      = 2'd2
    } state_t;
endpackage

// File: rtl/pipeline_hazard_sequencer_if.sv
// ID-stage hazard bus: pipeline status in, stall/flush/freeze controls and perf counters out.
interface pipeline_hazard_sequencer_if
    import hazard_defs::*;
#(
    parameter int REG_AW = REG_AW_DEF,
    parameter int CNT_W  = 16
);
    logic [REG_AW-1:0] src1, src2, exe_dest, mem_dest;
    logic              two_src, exe_wb_en, exe_mem_r_en, mem_wb_en;
    logic              forward_en, br_taken, mem_req, mem_ready;
    logic              hold_if_id, bubble, if_flush, freeze, mem_start, error;
    logic [CNT_W-1:0]  stall_cnt, flush_cnt;

    modport master (
        output src1, src2, two_src, exe_dest, exe_wb_en, exe_mem_r_en,
               mem_dest, mem_wb_en, forward_en, br_taken, mem_req, mem_ready,
        input  hold_if_id, bubble, if_flush, freeze, mem_start, error,
               stall_cnt, flush_cnt
    );

    modport slave (
        input  src1, src2, two_src, exe_dest, exe_wb_en, exe_mem_r_en,
               mem_dest, mem_wb_en, forward_en, br_taken, mem_req, mem_ready,
        output hold_if_id, bubble, if_flush, freeze, mem_start, error,
               stall_cnt, flush_cnt
    );
endinterface

// File: rtl/pipeline_hazard_sequencer_hazard_detect.sv
// Combinational RAW compare of the ID sources against the EXE and MEM destinations.
module hazard_detect
    import hazard_defs::*;
#(
    parameter int REG_AW = REG_AW_DEF
) (
    input  logic [REG_AW-1:0] src1,
    input  logic [REG_AW-1:0] src2,
    input  logic              two_src,
    input  logic [REG_AW-1:0] exe_dest,
    input  logic              exe_wb_en,
    input  logic [REG_AW-1:0] mem_dest,
    input  logic              mem_wb_en,
    output logic              hz_exe,
    output logic              hz_mem
);
    // r0 is hardwired zero, so a write to it never creates a dependency
    assign hz_exe = exe_wb_en && (exe_dest != '0) &&
                    ((exe_dest == src1) || (two_src && (exe_dest == src2)));
    assign hz_mem = mem_wb_en && (mem_dest != '0) &&
                    ((mem_dest == src1) || (two_src && (mem_dest == src2)));
endmodule

// File: rtl/pipeline_hazard_sequencer.sv
// ID-stage sequencer: RAW stalls, branch flush, and freeze during multi-cycle data-memory access.
module pipeline_hazard_sequencer
    import hazard_defs::*;
#(
    parameter int REG_AW      = REG_AW_DEF,
    parameter int MEM_TIMEOUT = 15,
    parameter int CNT_W       = 16
) (
    input  logic                         clk,
    input  logic                         rst,
    pipeline_hazard_sequencer_if.slave   bus
);
    state_t             state, state_nx;
    logic [TIMER_W-1:0] timer, timer_nx;
    logic [CNT_W-1:0]   stall_q, flush_q;
    logic               hz_exe, hz_mem, stall;
    logic               hold_c, bubble_c, flush_c, freeze_c, start_c, error_c;

    hazard_detect #(.REG_AW(REG_AW)) u_detect (
        .src1      (bus.src1),
        .src2      (bus.src2),
        .two_src   (bus.two_src),
        .exe_dest  (bus.exe_dest),
        .exe_wb_en (bus.exe_wb_en),
        .mem_dest  (bus.mem_dest),
        .mem_wb_en (bus.mem_wb_en),
        .hz_exe    (hz_exe),
        .hz_mem    (hz_mem)
    );

    // With forwarding only a load in EXE cannot be bypassed in time
    assign stall = bus.forward_en ? (hz_exe && bus.exe_mem_r_en) : (hz_exe || hz_mem);

    always_comb begin
        state_nx = state;
        timer_nx = timer;
        hold_c   = 1'b0;
        bubble_c = 1'b0;
        flush_c  = 1'b0;
        freeze_c = 1'b0;
        start_c  = 1'b0;
        error_c  = 1'b0;
        case (state)
            RUN: begin
                if (bus.mem_req) begin
                    freeze_c = 1'b1;
                    start_c  = 1'b1;
                    state_nx = MEM_WAIT;
                    timer_nx = TIMER_W'(1);
                end else begin
                    hold_c   = stall;
                    bubble_c = stall;
                    flush_c  = bus.br_taken && !stall;
                end
            end
            MEM_WAIT: begin
                freeze_c = !bus.mem_ready;
                if (bus.mem_ready)
                    state_nx = RUN;
                else if (timer == TIMER_W'(MEM_TIMEOUT))
                    state_nx = ERR;
                else
                    timer_nx = timer + 1'b1;
            end
            ERR: begin
                freeze_c = 1'b1;
                error_c  = 1'b1;
            end
            default: state_nx = RUN;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= RUN;
            timer   <= '0;
            stall_q <= '0;
            flush_q <= '0;
        end else begin
            state <= state_nx;
            timer <= timer_nx;
            if (bubble_c && (stall_q != '1)) stall_q <= stall_q + 1'b1;
            if (flush_c  && (flush_q != '1)) flush_q <= flush_q + 1'b1;
        end
    end

    assign bus.hold_if_id = hold_c   && rst;
    assign bus.bubble     = bubble_c && rst;
    assign bus.if_flush   = flush_c  && rst;
    assign bus.freeze     = freeze_c && rst;
    assign bus.mem_start  = start_c  && rst;
    assign bus.error      = error_c  && rst;
    assign bus.stall_cnt  = stall_q;
    assign bus.flush_cnt  = flush_q;
endmodule

// File: tb/tb_pipeline_hazard_sequencer.sv
// Directed bench for pipeline_hazard_sequencer; control vector is {hold,bubble,flush,freeze,start,error}.
module tb_pipeline_hazard_sequencer;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int   tests = 0;
    int   fails = 0;

    always #5 clk = ~clk;

    pipeline_hazard_sequencer_if #(.REG_AW(5), .CNT_W(4)) bus ();

    pipeline_hazard_sequencer #(.REG_AW(5), .MEM_TIMEOUT(15), .CNT_W(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    wire [5:0] ctl = {bus.hold_if_id, bus.bubble, bus.if_flush, bus.freeze, bus.mem_start, bus.error};

    task automatic idle();
        bus.src1 = '0; bus.src2 = '0; bus.two_src = 1'b0;
        bus.exe_dest = '0; bus.exe_wb_en = 1'b0; bus.exe_mem_r_en = 1'b0;
        bus.mem_dest = '0; bus.mem_wb_en = 1'b0;
        bus.forward_en = 1'b0; bus.br_taken = 1'b0;
        bus.mem_req = 1'b0; bus.mem_ready = 1'b0;
    endtask

    task automatic step();
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        idle();
        rst = 1'b0;
        step();
        rst = 1'b1;
    endtask

    task automatic test_reset();
        idle();
        rst = 1'b0;
        bus.mem_req = 1'b1; bus.br_taken = 1'b1;
        @(negedge clk);
        tests++; if (ctl !== 6'b000000) begin fails++; $display("FAIL reset_ctl got %b want %b", ctl, 6'b000000); end
        tests++; if ({bus.stall_cnt, bus.flush_cnt} !== 8'h00) begin fails++; $display("FAIL reset_cnt got %h want 00", {bus.stall_cnt, bus.flush_cnt}); end
        step();
    endtask

    task automatic test_raw_nofwd();
        do_reset();
        bus.exe_wb_en = 1'b1; bus.exe_dest = 5'd5; bus.src1 = 5'd5;
        @(negedge clk);
        tests++; if (ctl !== 6'b110000) begin fails++; $display("FAIL raw_exe got %b want %b", ctl, 6'b110000); end
        step();
        bus.exe_wb_en = 1'b0; bus.mem_wb_en = 1'b1; bus.mem_dest = 5'd5;
        @(negedge clk);
        tests++; if (ctl !== 6'b110000) begin fails++; $display("FAIL raw_mem got %b want %b", ctl, 6'b110000); end
        step();
        bus.mem_wb_en = 1'b0;
        @(negedge clk);
        tests++; if (ctl !== 6'b000000) begin fails++; $display("FAIL raw_clear got %b want %b", ctl, 6'b000000); end
        tests++; if (bus.stall_cnt !== 4'd2) begin fails++; $display("FAIL raw_stall_cnt got %0d want 2", bus.stall_cnt); end
        step();
    endtask

    task automatic test_load_use();
        do_reset();
        bus.forward_en = 1'b1;
        bus.exe_wb_en = 1'b1; bus.exe_mem_r_en = 1'b1; bus.exe_dest = 5'd3;
        bus.src1 = 5'd7; bus.src2 = 5'd3; bus.two_src = 1'b1;
        @(negedge clk);
        tests++; if (ctl !== 6'b110000) begin fails++; $display("FAIL lu_c1 got %b want %b", ctl, 6'b110000); end
        step();
        bus.exe_wb_en = 1'b0; bus.exe_mem_r_en = 1'b0; bus.mem_wb_en = 1'b1; bus.mem_dest = 5'd3;
        @(negedge clk);
        tests++; if (ctl !== 6'b000000) begin fails++; $display("FAIL lu_c2 got %b want %b", ctl, 6'b000000); end
        tests++; if (bus.stall_cnt !== 4'd1) begin fails++; $display("FAIL lu_stall_cnt got %0d want 1", bus.stall_cnt); end
        step();
        bus.mem_wb_en = 1'b0; bus.two_src = 1'b0;
        bus.exe_wb_en = 1'b1; bus.exe_mem_r_en = 1'b1;
        @(negedge clk);
        tests++; if (ctl !== 6'b000000) begin fails++; $display("FAIL lu_one_src got %b want %b", ctl, 6'b000000); end
        step();
        @(negedge clk);
        tests++; if (bus.stall_cnt !== 4'd1) begin fails++; $display("FAIL lu_stall_cnt2 got %0d want 1", bus.stall_cnt); end
    endtask

    task automatic test_branch();
        do_reset();
        bus.forward_en = 1'b1; bus.br_taken = 1'b1;
        @(negedge clk);
        tests++; if (ctl !== 6'b001000) begin fails++; $display("FAIL br_flush got %b want %b", ctl, 6'b001000); end
        step();
        bus.br_taken = 1'b0;
        @(negedge clk);
        tests++; if (ctl !== 6'b000000) begin fails++; $display("FAIL br_once got %b want %b", ctl, 6'b000000); end
        tests++; if (bus.flush_cnt !== 4'd1) begin fails++; $display("FAIL br_flush_cnt got %0d want 1", bus.flush_cnt); end
        step();
        bus.br_taken = 1'b1; bus.src1 = 5'd3;
        bus.exe_wb_en = 1'b1; bus.exe_mem_r_en = 1'b1; bus.exe_dest = 5'd3;
        @(negedge clk);
        tests++; if (ctl !== 6'b110000) begin fails++; $display("FAIL br_stall_c1 got %b want %b", ctl, 6'b110000); end
        step();
        bus.exe_wb_en = 1'b0; bus.exe_mem_r_en = 1'b0; bus.mem_wb_en = 1'b1; bus.mem_dest = 5'd3;
        @(negedge clk);
        tests++; if (ctl !== 6'b001000) begin fails++; $display("FAIL br_stall_c2 got %b want %b", ctl, 6'b001000); end
        step();
        idle(); bus.forward_en = 1'b1;
        @(negedge clk);
        tests++; if ({bus.stall_cnt, bus.flush_cnt} !== {4'd1, 4'd2}) begin fails++; $display("FAIL br_cnts got %h want 12", {bus.stall_cnt, bus.flush_cnt}); end
        step();
    endtask

    task automatic test_mem_access();
        do_reset();
        bus.mem_req = 1'b1; bus.br_taken = 1'b1;
        bus.exe_wb_en = 1'b1; bus.exe_dest = 5'd9; bus.src1 = 5'd9;
        @(negedge clk);
        tests++; if (ctl !== 6'b000110) begin fails++; $display("FAIL mem_start got %b want %b", ctl, 6'b000110); end
        step();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            tests++; if (ctl !== 6'b000100) begin fails++; $display("FAIL mem_wait%0d got %b want %b", i, ctl, 6'b000100); end
            step();
        end
        bus.mem_ready = 1'b1;
        @(negedge clk);
        tests++; if (ctl !== 6'b000000) begin fails++; $display("FAIL mem_ready got %b want %b", ctl, 6'b000000); end
        step();
        bus.mem_ready = 1'b0; bus.mem_req = 1'b0; bus.exe_wb_en = 1'b0;
        @(negedge clk);
        tests++; if (ctl !== 6'b001000) begin fails++; $display("FAIL mem_br_after got %b want %b", ctl, 6'b001000); end
        tests++; if (bus.stall_cnt !== 4'd0) begin fails++; $display("FAIL mem_no_stall got %0d want 0", bus.stall_cnt); end
        step();
    endtask

    task automatic test_back_to_back();
        do_reset();
        bus.mem_req = 1'b1;
        step();
        bus.mem_ready = 1'b1;
        @(negedge clk);
        tests++; if (ctl !== 6'b000000) begin fails++; $display("FAIL b2b_min got %b want %b", ctl, 6'b000000); end
        step();
        @(negedge clk);
        tests++; if (ctl !== 6'b000110) begin fails++; $display("FAIL b2b_start got %b want %b", ctl, 6'b000110); end
        step();
        bus.mem_ready = 1'b0;
        @(negedge clk);
        tests++; if (ctl !== 6'b000100) begin fails++; $display("FAIL b2b_wait got %b want %b", ctl, 6'b000100); end
        step();
    endtask

    task automatic test_timeout();
        do_reset();
        bus.mem_req = 1'b1;
        step();
        bus.mem_req = 1'b0;
        for (int i = 1; i <= 15; i++) begin
            @(negedge clk);
            tests++; if (ctl !== 6'b000100) begin fails++; $display("FAIL to_wait%0d got %b want %b", i, ctl, 6'b000100); end
            step();
        end
        bus.mem_ready = 1'b1; bus.mem_req = 1'b1; bus.br_taken = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            tests++; if (ctl !== 6'b000101) begin fails++; $display("FAIL to_err%0d got %b want %b", i, ctl, 6'b000101); end
            step();
        end
        rst = 1'b0;
        #1;
        tests++; if (ctl !== 6'b000000) begin fails++; $display("FAIL to_rst got %b want %b", ctl, 6'b000000); end
        idle();
        step();
        rst = 1'b1;
    endtask

    task automatic test_reg0_reset_midwait();
        do_reset();
        bus.exe_wb_en = 1'b1; bus.exe_dest = 5'd0; bus.mem_wb_en = 1'b1; bus.mem_dest = 5'd0;
        bus.src1 = 5'd0; bus.src2 = 5'd0; bus.two_src = 1'b1;
        @(negedge clk);
        tests++; if (ctl !== 6'b000000) begin fails++; $display("FAIL r0_nostall got %b want %b", ctl, 6'b000000); end
        step();
        bus.exe_dest = 5'd4; bus.src1 = 5'd4;
        step();
        idle(); bus.mem_req = 1'b1;
        step();
        bus.mem_req = 1'b0;
        @(negedge clk);
        tests++; if ({ctl, bus.stall_cnt} !== {6'b000100, 4'd1}) begin fails++; $display("FAIL r0_wait got %b want %b", {ctl, bus.stall_cnt}, {6'b000100, 4'd1}); end
        rst = 1'b0;
        #1;
        tests++; if ({ctl, bus.stall_cnt, bus.flush_cnt} !== 14'd0) begin fails++; $display("FAIL midwait_rst got %b want 0", {ctl, bus.stall_cnt, bus.flush_cnt}); end
        step();
        rst = 1'b1;
        @(negedge clk);
        tests++; if (ctl !== 6'b000000) begin fails++; $display("FAIL midwait_run got %b want %b", ctl, 6'b000000); end
        step();
        bus.mem_req = 1'b1;
        @(negedge clk);
        tests++; if (ctl !== 6'b000110) begin fails++; $display("FAIL midwait_restart got %b want %b", ctl, 6'b000110); end
        step();
    endtask

    task automatic test_saturation();
        do_reset();
        bus.exe_wb_en = 1'b1; bus.exe_dest = 5'd6; bus.src1 = 5'd6;
        repeat (20) step();
        idle(); bus.br_taken = 1'b1;
        repeat (18) step();
        idle();
        @(negedge clk);
        tests++; if (bus.stall_cnt !== 4'hF) begin fails++; $display("FAIL sat_stall got %0d want 15", bus.stall_cnt); end
        tests++; if (bus.flush_cnt !== 4'hF) begin fails++; $display("FAIL sat_flush got %0d want 15", bus.flush_cnt); end
        step();
    endtask

    initial begin
        test_reset();
        test_raw_nofwd();
        test_load_use();
        test_branch();
        test_mem_access();
        test_back_to_back();
        test_timeout();
        test_reg0_reset_midwait();
        test_saturation();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
